// File: rtl/mem_load_store_unit.sv
// rtl/mem_load_store_unit.sv - multi-cycle load/store stage with read-modify-write for sub-word stores
module mem_load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] mdr_out,
    output logic [1:0]  cnt_out,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_MERGE, S_WR, S_DONE, S_ERR
    } state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] merged;
    logic [31:0] load_shifted;
    logic [31:0] wait_cnt;
    logic        to_q;
    logic        bad_req;
    logic        expire;

    assign bad_req = (size == 2'd3) || (size == 2'd2 && addr[0]) ||
                     (size == 2'd0 && addr[1:0] != 2'b00);
    // Counter has already seen TIMEOUT-1 idle cycles and this one is idle too.
    assign expire  = (TIMEOUT != 0) && !mem_ready && (wait_cnt == 32'(TIMEOUT - 1));

    always_comb begin
        load_shifted = mem_rdata;
        if (size_q == 2'd1)
            load_shifted = mem_rdata >> {lane_q, 3'b000};
        else if (size_q == 2'd2)
            load_shifted = mem_rdata >> {lane_q[1], 4'b0000};
    end

    always_comb begin
        merged = merge_q;
        if (size_q == 2'd1)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        misalign  = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (bad_req)
                        state_nxt = S_ERR;
                    else if (we && size == 2'd0)
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;
                end
            end
            S_RD: begin
                mem_rd = 1'b1;
                if (mem_ready)
                    state_nxt = we_q ? S_MERGE : S_DONE;
                else if (expire)
                    state_nxt = S_ERR;
            end
            S_MERGE: state_nxt = S_WR;
            S_WR: begin
                mem_wr = 1'b1;
                if (mem_ready)
                    state_nxt = S_DONE;
                else if (expire)
                    state_nxt = S_ERR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                done      = 1'b1;
                misalign  = !to_q;
                timeout   = to_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            lane_q    <= 2'd0;
            wdata_q   <= 32'd0;
            merge_q   <= 32'd0;
            wait_cnt  <= 32'd0;
            to_q      <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mdr_out   <= 32'd0;
            cnt_out   <= 2'd0;
        end else begin
            if (state == S_RD || state == S_WR)
                wait_cnt <= mem_ready ? 32'd0 : wait_cnt + 32'd1;
            else
                wait_cnt <= 32'd0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        we_q     <= we;
                        size_q   <= size;
                        lane_q   <= addr[1:0];
                        wdata_q  <= wdata;
                        cnt_out  <= size;
                        mem_addr <= {addr[31:2], 2'b00};
                        to_q     <= 1'b0;
                        if (we && size == 2'd0)
                            mem_wdata <= wdata;
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        if (we_q)
                            merge_q <= mem_rdata;
                        else
                            mdr_out <= load_shifted;
                    end else if (expire) begin
                        to_q <= 1'b1;
                    end
                end
                S_MERGE: mem_wdata <= merged;
                S_WR: begin
                    if (!mem_ready && expire)
                        to_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_load_store_unit.md
Name: mem_load_store_unit

Overview:
- Multi-cycle memory access stage that sits directly upstream of the load width selector (word/byte/halfword zero-extender).
- Accepts one load or store request from the control FSM and drives a word-only memory port with a ready handshake.
- Stores narrower than a word are done as read-modify-write.
- Loads produce a lane-shifted memory data register plus a 2-bit width code that the downstream selector consumes directly.

Parameters:
- TIMEOUT, 16: maximum consecutive memory-wait cycles per access before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request strobe, sampled in IDLE only
- we  in  1  1 = store, 0 = load
- size  in  2  access width: 0 = word, 1 = byte, 2 = halfword, 3 = illegal
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- mem_addr  out  32  word address: {addr[31:2], 2'b00}
- mem_rd  out  1  memory read request, held until mem_ready
- mem_wr  out  1  memory write request, held until mem_ready
- mem_wdata  out  32  write data word
- mem_rdata  in  32  read data, valid when mem_ready is high
- mem_ready  in  1  memory completion for the current rd/wr cycle
- mdr_out  out  32  memory data register, lane-shifted down to bit 0
- cnt_out  out  2  width code for the downstream selector; equals the latched size
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- misalign  out  1  one-cycle pulse, coincident with done, on an alignment or illegal-size error
- timeout  out  1  one-cycle pulse, coincident with done, on a memory timeout

Behaviour:
- Reset: state IDLE; mdr_out, cnt_out, mem_addr and mem_wdata are 0; mem_rd, mem_wr, busy, done, misalign and timeout are 0.
- Reset mid-access aborts the access immediately: mem_rd and mem_wr drop asynchronously and no done pulse is issued.
- States: IDLE, RD, MERGE, WR, DONE, ERR.
- IDLE:
  - On start, latch we, size, addr and wdata; cnt_out takes size.
  - Misaligned request (size 2 with addr[0]=1, size 0 with addr[1:0]≠0, or size 3) goes to ERR with no memory access.
  - Otherwise: load, or store with size 1/2, goes to RD; word store goes to WR with mem_wdata = wdata.
- start is ignored while busy.
- RD: mem_rd=1. On mem_ready:
  - Load: mdr_out = mem_rdata >> (8*addr[1:0]) for byte, mem_rdata >> (16*addr[1]) for halfword, mem_rdata for word (logical shift, upper bits are not masked here). Next state DONE.
  - Sub-word store: capture mem_rdata into the merge register, next state MERGE.
- MERGE (one cycle):
  - mem_wdata = captured word with byte lane addr[1:0] replaced by wdata[7:0] (byte store), or half lane addr[1] replaced by wdata[15:0] (halfword store).
  - Next state WR.
- WR: mem_wr=1 until mem_ready, then DONE. mdr_out is unchanged by stores.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1, plus misalign=1 or timeout=1 as applicable, for one cycle, then IDLE. mdr_out is unchanged.
- Latency with zero wait states (start sampled in cycle 0):
  - Load: RD in cycle 1, done in cycle 2.
  - Word store: done in cycle 2.
  - Sub-word store: RD cycle 1, MERGE cycle 2, WR cycle 3, done in cycle 4.
- Each wait cycle adds one cycle of latency.
- Timeout:
  - A wait counter resets on entry to RD or WR and increments each cycle mem_ready is low.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT: drop mem_rd/mem_wr, go to ERR with the timeout pulse, and leave memory unwritten.
- Little-endian: byte 0 occupies bits 7:0.
- mem_addr is stable for the whole access.

Test Plan:
- Byte load: addr=0x103, mem_rdata=0xAABBCCDD, ready immediate → mem_addr=0x100; done in cycle 2; mdr_out=0x000000AA; cnt_out=1.
- Halfword store: addr=0x202, wdata=0x1234, old word 0x55667788 → read of 0x200, then mem_wr with mem_wdata=0x12347788; done in cycle 4.
- Misaligned word load at addr=0x6, and size=3 at addr=0x0 → misalign and done pulse in cycle 1; mem_rd never asserted; mdr_out unchanged.
- Wait states: word load with mem_ready low for 3 cycles → mem_rd high for 4 cycles, done in cycle 5; a start pulse during busy is ignored.
- Timeout: TIMEOUT=16, mem_ready held low → mem_rd high for exactly 16 cycles, then timeout and done pulse, back to IDLE.
- Reset mid-WR of a byte store → mem_wr drops in the same cycle; all outputs 0; next start is served normally.
